// File: rtl/cs_dac_pkg.sv
// Shared types and constants for the segmented current-steering DAC driver.
package cs_dac_pkg;

  localparam int unsigned THERM_UNITS = 17;
  localparam int unsigned BIN_BITS    = 6;
  localparam int unsigned ICAL_W      = 5;
  localparam int unsigned CODE_W      = 11;
  localparam int unsigned TCNT_W      = CODE_W - BIN_BITS;
  localparam logic [CODE_W-1:0] CODE_MAX = 11'd1151;

  typedef enum logic [1:0] {
    OFF,
    WAKE,
    CAL,
    RUN
  } state_e;

  // One decoded sample: thermometer units plus redundant+binary bits.
  typedef struct packed {
    logic [THERM_UNITS-1:0] therm;
    logic [BIN_BITS:0]      bin;
  } dac_word_t;

  // Clamp a sample to the DAC full scale.
  function automatic logic [CODE_W-1:0] sat_code(input logic [CODE_W-1:0] c);
    return (c > CODE_MAX) ? CODE_MAX : c;
  endfunction

endpackage

// File: rtl/cs_dac_therm_dec.sv
// Count-to-thermometer decoder; counts above the unit count give all ones.
module cs_dac_therm_dec
  import cs_dac_pkg::*;
(
  input  logic [TCNT_W-1:0]      count_i,
  output logic [THERM_UNITS-1:0] therm_o
);

  // Unit k is on when the count exceeds k.
  always_comb begin
    therm_o = '0;
    for (int unsigned k = 0; k < THERM_UNITS; k++) begin
      therm_o[k] = (TCNT_W'(k) < count_i);
    end
  end

endmodule

// File: rtl/cs_dac_driver.sv
// Power-up sequencing, calibration sweep and sample decode for the DAC macro.
module cs_dac_driver
  import cs_dac_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES = 64,
  parameter int unsigned CAL_STEPS   = 23,
  parameter int unsigned CAL_DWELL   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   code_valid,
  input  logic [CODE_W-1:0]      code,
  output logic                   code_ready,
  input  logic                   red_en,
  input  logic                   cal_cmp,
  input  logic [1:0]             atb_sel,
  output logic                   pdb,
  output logic [1:0]             atb_ena,
  output logic [BIN_BITS:0]      datain,
  output logic [BIN_BITS:0]      datainb,
  output logic [THERM_UNITS-1:0] datatherm,
  output logic [THERM_UNITS-1:0] datathermb,
  output logic [ICAL_W-1:0]      dataical,
  output logic                   cal_done,
  output logic                   cal_fail
);

  localparam int unsigned CNT_W = 16;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ICAL_W-1:0]   ical_q, ical_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic                pdb_q, ready_q;
  logic [1:0]          atb_q;
  logic                sync1_q, sync2_q;
  logic                run_d, accept_c;

  logic [CODE_W-1:0]      code_s1_q;
  logic                   red_s1_q, vld_s1_q;
  dac_word_t              word_s2_q, word_c;
  logic                   vld_s2_q;
  logic [CODE_W-1:0]      sat_c;
  logic [THERM_UNITS-1:0] therm_c;
  logic [BIN_BITS:0]      datain_q, datainb_q;
  logic [THERM_UNITS-1:0] datatherm_q, datathermb_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= OFF;
    else     state_q <= state_d;
  end

  // Next state, dwell/wake counter and calibration result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ical_d  = ical_q;
    done_d  = done_q;
    fail_d  = fail_q;
    case (state_q)
      OFF: begin
        if (enable) begin
          state_d = WAKE;
          cnt_d   = '0;
        end
      end
      WAKE: begin
        if (cnt_q == CNT_W'(WAKE_CYCLES)) begin
          state_d = CAL;
          cnt_d   = '0;
          ical_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAL: begin
        if (cnt_q == CNT_W'(CAL_DWELL - 1)) begin
          cnt_d = '0;
          if (sync2_q) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else if (ical_q == ICAL_W'(CAL_STEPS - 1)) begin
            state_d = RUN;
            done_d  = 1'b1;
            fail_d  = 1'b1;
          end else begin
            ical_d = ical_q + ICAL_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: ;
      default: state_d = OFF;
    endcase
    if (!enable) begin
      state_d = OFF;
      cnt_d   = '0;
      ical_d  = '0;
      done_d  = 1'b0;
      fail_d  = 1'b0;
    end
  end

  assign run_d    = (state_d == RUN);
  assign accept_c = code_valid & ready_q;

  // Control registers; pdb lags the WAKE entry by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      ical_q  <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      pdb_q   <= 1'b0;
      ready_q <= 1'b0;
      atb_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ical_q  <= ical_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      pdb_q   <= enable & (state_q != OFF);
      ready_q <= run_d;
      atb_q   <= (state_d == OFF) ? 2'b00 : atb_sel;
    end
  end

  // Two-flop synchronizer for the asynchronous comparator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= cal_cmp;
      sync2_q <= sync1_q;
    end
  end

  assign sat_c = sat_code(code_s1_q);

  cs_dac_therm_dec u_therm_dec (
    .count_i (sat_c[CODE_W-1:BIN_BITS]),
    .therm_o (therm_c)
  );

  // Decoded word from the captured sample.
  always_comb begin
    word_c.therm = therm_c;
    word_c.bin   = {red_s1_q, sat_c[BIN_BITS-1:0]};
  end

  // Capture, decode and output stages; flushed whenever not running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_s1_q    <= '0;
      red_s1_q     <= 1'b0;
      vld_s1_q     <= 1'b0;
      word_s2_q    <= '0;
      vld_s2_q     <= 1'b0;
      datain_q     <= '0;
      datainb_q    <= '1;
      datatherm_q  <= '0;
      datathermb_q <= '1;
    end else if (!run_d) begin
      code_s1_q    <= '0;
      red_s1_q     <= 1'b0;
      vld_s1_q     <= 1'b0;
      word_s2_q    <= '0;
      vld_s2_q     <= 1'b0;
      datain_q     <= '0;
      datainb_q    <= '1;
      datatherm_q  <= '0;
      datathermb_q <= '1;
    end else begin
      vld_s1_q <= accept_c;
      if (accept_c) begin
        code_s1_q <= code;
        red_s1_q  <= red_en;
      end
      vld_s2_q <= vld_s1_q;
      if (vld_s1_q) word_s2_q <= word_c;
      if (vld_s2_q) begin
        datain_q     <= word_s2_q.bin;
        datainb_q    <= ~word_s2_q.bin;
        datatherm_q  <= word_s2_q.therm;
        datathermb_q <= ~word_s2_q.therm;
      end
    end
  end

  assign code_ready = ready_q;
  assign pdb        = pdb_q;
  assign atb_ena    = atb_q;
  assign datain     = datain_q;
  assign datainb    = datainb_q;
  assign datatherm  = datatherm_q;
  assign datathermb = datathermb_q;
  assign dataical   = ical_q;
  assign cal_done   = done_q;
  assign cal_fail   = fail_q;

endmodule

// File: tb/tb_cs_dac_driver.sv
// Scoreboard bench for cs_dac_driver: sequencing, calibration, decode, shutdown.
module tb_cs_dac_driver;

  localparam int W = 64;
  localparam int S = 23;
  localparam int D = 8;

  logic        clk, rst, enable, code_valid, code_ready, red_en, cal_cmp;
  logic [10:0] code;
  logic [1:0]  atb_sel, atb_ena;
  logic        pdb, cal_done, cal_fail;
  logic [6:0]  datain, datainb;
  logic [16:0] datatherm, datathermb;
  logic [4:0]  dataical;

  typedef struct {
    int          edge_n;
    logic [16:0] therm;
    logic [6:0]  bin;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  cs_dac_driver #(.WAKE_CYCLES(W), .CAL_STEPS(S), .CAL_DWELL(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .code_valid (code_valid),
    .code       (code),
    .code_ready (code_ready),
    .red_en     (red_en),
    .cal_cmp    (cal_cmp),
    .atb_sel    (atb_sel),
    .pdb        (pdb),
    .atb_ena    (atb_ena),
    .datain     (datain),
    .datainb    (datainb),
    .datatherm  (datatherm),
    .datathermb (datathermb),
    .dataical   (dataical),
    .cal_done   (cal_done),
    .cal_fail   (cal_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: complement invariant every cycle, scoreboard pop at 2-edge latency.
  always @(negedge clk) begin
    check("inv_bin", 32'(datain ^ datainb), 32'h7F);
    check("inv_therm", 32'(datatherm ^ datathermb), 32'h1FFFF);
    if (!rst && sb_q.size() > 0) begin
      if (sb_q[0].edge_n + 2 == cyc) begin
        mon_e = sb_q.pop_front();
        check("sb_therm", 32'(datatherm), 32'(mon_e.therm));
        check("sb_bin", 32'(datain), 32'(mon_e.bin));
      end else if (sb_q[0].edge_n + 2 < cyc) begin
        mon_e = sb_q.pop_front();
        check("sb_late", 32'(cyc), 32'(mon_e.edge_n + 2));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_off(input string tag);
    check({tag, "_pdb"}, 32'(pdb), 0);
    check({tag, "_ical"}, 32'(dataical), 0);
    check({tag, "_done"}, 32'(cal_done), 0);
    check({tag, "_fail"}, 32'(cal_fail), 0);
    check({tag, "_ready"}, 32'(code_ready), 0);
    check({tag, "_atb"}, 32'(atb_ena), 0);
    check({tag, "_din"}, 32'(datain), 0);
    check({tag, "_dinb"}, 32'(datainb), 32'h7F);
    check({tag, "_dth"}, 32'(datatherm), 0);
    check({tag, "_dthb"}, 32'(datathermb), 32'h1FFFF);
  endtask

  // Called at a negedge with enable=1; the next posedge is edge 0.
  task automatic run_seq(input int trip, input int abort_k);
    int e_run;
    int ical_exp;
    e_run = (trip < 0) ? (1 + W + S * D) : (1 + W + (trip + 1) * D);
    cal_cmp = 1'b0;
    for (int k = 0; k <= e_run + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (trip >= 0 && k == 1 + W + trip * D) cal_cmp = 1'b1;
      check("seq_pdb", 32'(pdb), (k >= 1) ? 1 : 0);
      if (k < e_run) begin
        ical_exp = (k <= W) ? 0 : (k - 1 - W) / D;
        check("seq_ical", 32'(dataical), 32'(ical_exp));
        check("seq_done", 32'(cal_done), 0);
        check("seq_fail", 32'(cal_fail), 0);
        check("seq_ready", 32'(code_ready), 0);
      end else begin
        check("run_ical", 32'(dataical), (trip < 0) ? 32'(S - 1) : 32'(trip));
        check("run_done", 32'(cal_done), 1);
        check("run_fail", 32'(cal_fail), (trip < 0) ? 1 : 0);
        check("run_ready", 32'(code_ready), 1);
        check("run_din0", 32'(datain), 0);
      end
      if (k == abort_k) return;
    end
  endtask

  task automatic shutdown(input string tag);
    enable = 1'b0;
    tick(1);
    sb_q.delete();
    check_off(tag);
  endtask

  task automatic send(input logic [10:0] c, input logic r,
                      input logic [16:0] et, input logic [6:0] eb);
    exp_t e;
    check("send_ready", 32'(code_ready), 1);
    code = c;
    red_en = r;
    code_valid = 1'b1;
    e.edge_n = cyc + 1;
    e.therm = et;
    e.bin = eb;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    code_valid = 1'b0;
    red_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; code_valid = 1'b0; code = '0;
    red_en = 1'b0; cal_cmp = 1'b0; atb_sel = 2'b11;
    #12;
    check_off("reset");
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    check_off("idle_off");

    // Full sweep without a comparator trip.
    enable = 1'b1;
    run_seq(-1, -1);
    check("atb_run", 32'(atb_ena), 32'h3);
    shutdown("off_run");

    // Trip during step 9.
    enable = 1'b1;
    run_seq(9, -1);

    // Directed decode vectors.
    send(11'd357,  1'b0, 17'h0001F, 7'b0100101);
    send(11'd1151, 1'b0, 17'h1FFFF, 7'h3F);
    send(11'd2000, 1'b0, 17'h1FFFF, 7'h3F);
    send(11'd0,    1'b1, 17'h00000, 7'h40);
    send(11'd700,  1'b1, 17'h003FF, 7'h7C);
    tick(4);
    check("hold_din", 32'(datain), 32'h7C);
    check("hold_dth", 32'(datatherm), 32'h3FF);
    check("hold_done", 32'(cal_done), 1);

    // Back-to-back stream 0..127.
    for (int i = 0; i < 128; i++) begin
      send(11'(i), 1'b0, (i < 64) ? 17'h0 : 17'h1, 7'(i % 64));
    end
    tick(4);
    check("sb_empty", 32'(sb_q.size()), 0);
    check("hold_stream", 32'(datain), 32'h3F);

    // Drop enable in RUN with a sample on the same edge: sample discarded.
    code = 11'd1000;
    code_valid = 1'b1;
    enable = 1'b0;
    tick(1);
    code_valid = 1'b0;
    sb_q.delete();
    check_off("off_run_smp");
    tick(3);
    check_off("off_run_hold");

    // Drop enable mid CAL step 5, then restart from scratch.
    enable = 1'b1;
    run_seq(-1, 1 + W + 5 * D + 3);
    shutdown("off_cal");
    enable = 1'b1;
    run_seq(2, -1);

    // Asynchronous reset in RUN.
    send(11'd1151, 1'b0, 17'h1FFFF, 7'h3F);
    tick(3);
    check("pre_rst_din", 32'(datain), 32'h3F);
    #3;
    rst = 1'b1;
    #1;
    sb_q.delete();
    check_off("async_rst");
    @(negedge clk);
    rst = 1'b0;
    run_seq(0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
